button_debouncer_n: RTL
=======================

// Module: button_debouncer_n
// PURPOSE
//   Multi-channel, parametrised successor to the single-button debouncer. Per channel:
//   synchroniser, glitch-rejecting confirm counter, and level/edge/long-press outputs.
//   Sits between raw board button pins and control logic on the pll_clk domain.
//   Any bounce during the confirm window restarts it: a change is accepted only if held stable.
// PARAMETERS
//   CHANNELS    4      number of independent button channels
//   COUNT_BITS  15     confirm counter width; DEBOUNCE = 2**COUNT_BITS cycles
//   SYNC_STAGES 2      synchroniser flops per channel (>=2)
//   LONG_BITS   24     hold counter width; LONG = 2**LONG_BITS-1 cycles
//   IDLE_LEVEL  all 1s [CHANNELS-1:0] released pin level per channel (1 = active-low button)
// PORTS
//   clk           in   1         system clock (pll_clk)
//   resetn        in   1         asynchronous, active-low reset
//   button_pin    in   CHANNELS  raw asynchronous button inputs
//   level         out  CHANNELS  debounced level
//   rising_edge   out  CHANNELS  1-cycle pulse when level goes 0->1
//   falling_edge  out  CHANNELS  1-cycle pulse when level goes 1->0
//   pressed       out  CHANNELS  level != IDLE_LEVEL
//   long_press    out  CHANNELS  1-cycle pulse, once per press, after LONG cycles pressed
// BEHAVIOUR
//   Reset (async, resetn=0): sync chain=IDLE_LEVEL, level=IDLE_LEVEL, pressed=0,
//     rising/falling/long_press=0, counters=0, FSM=STABLE; outputs change immediately.
//   Channels fully independent; several channels may pulse in the same cycle.
//   Sync: button_pin -> SYNC_STAGES flops -> s (last stage).
//   FSM per channel, evaluated on each clk edge:
//     STABLE : s==level -> stay. s!=level -> CONFIRM, cnt<=1.
//     CONFIRM: s==level -> STABLE, cnt<=0 (glitch rejected, no output change).
//              s!=level, cnt<MAX -> cnt<=cnt+1 (MAX = 2**COUNT_BITS-1).
//              s!=level, cnt==MAX -> level<=s, edge pulse, cnt<=0, STABLE.
//   Acceptance: s must differ for DEBOUNCE consecutive sampled edges; DEBOUNCE-1 rejected.
//   Latency: clean pin step -> level/edge change exactly SYNC_STAGES+DEBOUNCE cycles later.
//   Edges: rising_edge/falling_edge registered on the same edge as level; high one cycle.
//   Hold counter hc (LONG_BITS):
//     cleared whenever level==IDLE_LEVEL (incl. the edge level becomes pressed);
//     while pressed, hc<=hc+1, saturating at all-ones.
//     long_press<=1 only on the edge hc goes MAX_L-1 -> MAX_L (= LONG cycles after
//     level goes pressed); never re-fires until release and a new press.
//   Release before LONG cycles: hc cleared, no long_press.
//   Press ending on the LONG edge (level goes idle that edge): no long_press.
//   Reset mid-CONFIRM or mid-hold: all state discarded; after resetn rises with pin still
//     pressed, full SYNC_STAGES+DEBOUNCE latency applies again.
//   No counter wraps: cnt bounded by FSM, hc saturates.
// TESTING (CHANNELS=4, COUNT_BITS=3 -> DEBOUNCE=8, SYNC_STAGES=2, LONG_BITS=5 -> LONG=31)
//   Reset: resetn=0, pins=4'hF -> level=4'hF, pressed=0, all pulses 0; hold 100 cycles, no change.
//   Clean press: pin0 1->0 held -> level[0]=0 and falling_edge[0] pulse exactly 10 cycles
//     later, one cycle wide; other channels quiet; release -> rising_edge[0] 10 cycles later.
//   Glitch boundary: pin1 low 7 cycles then high -> no output change ever;
//     pin1 low 8 cycles then high -> exactly one falling_edge[1] then one rising_edge[1].
//   Bounce: pin2 low 5, high 2, low steady -> single falling_edge[2] 10 cycles after last fall.
//   Long press: pin3 held low 60 cycles -> long_press[3] single pulse 31 cycles after
//     level[3] falls; second press released 20 cycles after fall -> no long_press.
//   Simultaneous + reset mid-op: all pins fall same cycle -> 4 falling_edge pulses same cycle;
//     resetn low 3 cycles during CONFIRM with pins held low -> level=4'hF at once,
//     falls 10 cycles after resetn rises.

Source files
------------

// File: rtl/button_debouncer_n_if.sv
// Button debouncer bundle: raw pins in, debounced level/edge/long-press flags out.
// master = control-side user (drives the pins in a bench), slave = the debouncer.
interface button_debouncer_n_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button_pin;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rising_edge;
  logic [CHANNELS-1:0] falling_edge;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] long_press;

  modport master (
    output button_pin,
    input  level,
    input  rising_edge,
    input  falling_edge,
    input  pressed,
    input  long_press
  );

  modport slave (
    input  button_pin,
    output level,
    output rising_edge,
    output falling_edge,
    output pressed,
    output long_press
  );
endinterface

// File: rtl/button_debouncer_n.sv
// Multi-channel button debouncer on the pll_clk domain.
// Each channel: SYNC_STAGES-flop synchroniser, a STABLE/CONFIRM FSM that only
// accepts a new level after it has been seen for 2**COUNT_BITS consecutive
// cycles (any bounce restarts the window), edge pulses registered with the
// level, and a saturating hold counter that fires one long_press pulse
// 2**LONG_BITS-1 cycles into a press.
module button_debouncer_n #(
  parameter int                   CHANNELS    = 4,
  parameter int                   COUNT_BITS  = 15,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   LONG_BITS   = 24,
  parameter logic [CHANNELS-1:0]  IDLE_LEVEL  = '1
) (
  input  logic                clk,
  input  logic                resetn,
  button_debouncer_n_if.slave bus
);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_t;

  localparam logic [COUNT_BITS-1:0] CNT_MAX   = {COUNT_BITS{1'b1}};
  localparam logic [COUNT_BITS-1:0] CNT_ONE   = COUNT_BITS'(1);
  localparam logic [LONG_BITS-1:0]  HOLD_MAX  = {LONG_BITS{1'b1}};
  localparam logic [LONG_BITS-1:0]  HOLD_FIRE = HOLD_MAX - LONG_BITS'(1);

  // Confirm counter step; the FSM never calls it at CNT_MAX, the guard just
  // makes the no-wrap property local to the function.
  function automatic logic [COUNT_BITS-1:0] cnt_inc(input logic [COUNT_BITS-1:0] v);
    cnt_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Hold counter step, saturating at all-ones so a very long press never wraps
  // back through the long-press threshold.
  function automatic logic [LONG_BITS-1:0] hold_sat_inc(input logic [LONG_BITS-1:0] v);
    hold_sat_inc = (v == HOLD_MAX) ? v : v + LONG_BITS'(1);
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    localparam logic IDLE = IDLE_LEVEL[ch];

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p1;
    state_t                 state_p1;
    logic [COUNT_BITS-1:0]  cnt_p1;
    logic                   level_p1;
    logic                   rise_p1;
    logic                   fall_p1;
    logic                   accept;
    logic                   level_nxt;
    logic                   held;
    logic [LONG_BITS-1:0]   hc_p2;
    logic                   pressed_p2;
    logic                   long_p2;

    // ---- stage 0: synchroniser, reset to the released level so a reset
    // never looks like a press.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_p0 <= {SYNC_STAGES{IDLE}};
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.button_pin[ch]};
      end
    end

    assign s_p1 = sync_p0[SYNC_STAGES-1];

    // Look-ahead of the FSM's level update, used by the hold counter so it can
    // clear on the same edge a press ends.
    always_comb begin
      accept    = 1'b0;
      level_nxt = level_p1;
      if (state_p1 == ST_CONFIRM && s_p1 != level_p1 && cnt_p1 == CNT_MAX) begin
        accept    = 1'b1;
        level_nxt = s_p1;
      end
      held = (level_p1 != IDLE) && (level_nxt != IDLE);
    end

    // ---- stage 1: confirm FSM, debounced level and its edge pulses.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_p1 <= ST_STABLE;
        cnt_p1   <= '0;
        level_p1 <= IDLE;
        rise_p1  <= 1'b0;
        fall_p1  <= 1'b0;
      end else begin
        rise_p1 <= 1'b0;
        fall_p1 <= 1'b0;
        case (state_p1)
          ST_STABLE: begin
            if (s_p1 != level_p1) begin
              state_p1 <= ST_CONFIRM;
              cnt_p1   <= CNT_ONE;
            end
          end
          ST_CONFIRM: begin
            if (s_p1 == level_p1) begin
              // Bounced back inside the window: drop the candidate quietly.
              state_p1 <= ST_STABLE;
              cnt_p1   <= '0;
            end else if (cnt_p1 != CNT_MAX) begin
              cnt_p1 <= cnt_inc(cnt_p1);
            end else begin
              level_p1 <= s_p1;
              rise_p1  <= s_p1;
              fall_p1  <= ~s_p1;
              cnt_p1   <= '0;
              state_p1 <= ST_STABLE;
            end
          end
          default: begin
            state_p1 <= ST_STABLE;
            cnt_p1   <= '0;
          end
        endcase
      end
    end

    // ---- stage 2: pressed flag, hold counter and one-shot long-press pulse.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hc_p2      <= '0;
        pressed_p2 <= 1'b0;
        long_p2    <= 1'b0;
      end else begin
        pressed_p2 <= (level_nxt != IDLE);
        long_p2    <= 1'b0;
        if (!held) begin
          hc_p2 <= '0;
        end else begin
          hc_p2   <= hold_sat_inc(hc_p2);
          long_p2 <= (hc_p2 == HOLD_FIRE);
        end
      end
    end

    assign bus.level[ch]        = level_p1;
    assign bus.rising_edge[ch]  = rise_p1;
    assign bus.falling_edge[ch] = fall_p1;
    assign bus.pressed[ch]      = pressed_p2;
    assign bus.long_press[ch]   = long_p2;

    logic unused_accept;
    assign unused_accept = accept;
  end

endmodule
